stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/stopwatch_counter_bcd60.sv | 44 ++++
 rtl/stopwatch_counter.sv | 123 ++++++++++++
 tb/tb_stopwatch_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM state encoding,
// the zero-extended BCD digit type and the per-field maximum (59).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    typedef logic [4:0] digit_t;

    localparam int unsigned FIELD_MAX = 59;
    localparam digit_t      TENS_MAX  = digit_t'(FIELD_MAX / 10);
    localparam digit_t      UNITS_MAX = digit_t'(FIELD_MAX % 10);

    function automatic logic field_at_max(input digit_t tens, input digit_t units);
        return (tens == TENS_MAX) && (units == UNITS_MAX);
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd60.sv
// bcd60: one 00-59 BCD field (tens/units) with increment, synchronous clear
// and a carry-out flag that is high while the field sits at 59.
module bcd60
    import stopwatch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr,
    input  logic   inc,
    output digit_t tens,
    output digit_t units,
    output logic   carry
);

    digit_t tens_r;
    digit_t units_r;

    // Digit registers: clear wins over increment; 59 wraps to 00.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tens_r  <= 5'd0;
            units_r <= 5'd0;
        end else if (clr) begin
            tens_r  <= 5'd0;
            units_r <= 5'd0;
        end else if (inc) begin
            if (units_r == UNITS_MAX) begin
                units_r <= 5'd0;
                tens_r  <= (tens_r == TENS_MAX) ? 5'd0 : tens_r + 5'd1;
            end else begin
                units_r <= units_r + 5'd1;
            end
        end else begin
            tens_r  <= tens_r;
            units_r <= units_r;
        end
    end

    // Carry-out means "the next increment wraps"; the parent gates it with inc.
    assign carry = field_at_max(tens_r, units_r);
    assign tens  = tens_r;
    assign units = units_r;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with run/pause/adjust FSM and free-running prescalers.
// Define STOPWATCH_ROLLOVER_EN to wrap 59:59 -> 00:00; otherwise it holds and pauses.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int ADJ_HZ = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause_p,
    input  logic        clr_p,
    input  logic        adj,
    input  logic        sel,
    output logic [4:0]  min_l,
    output logic [4:0]  min_r,
    output logic [4:0]  sec_l,
    output logic [4:0]  sec_r,
    output logic [26:0] blink_cnt,
    output logic        running
);

    localparam logic [26:0] TICK1_TERM = 27'(CLK_HZ - 1);
    localparam logic [26:0] TICKA_TERM = 27'((CLK_HZ / ADJ_HZ) - 1);
`ifdef STOPWATCH_ROLLOVER_EN
    localparam logic ROLLOVER = 1'b1;
`else
    localparam logic ROLLOVER = 1'b0;
`endif

    logic [26:0] cnt_r;
    logic [26:0] adj_cnt_r;
    state_t      state_r;
    state_t      next_state_s;
    logic        running_r;
    logic        tick1_s;
    logic        tick_a_s;
    logic        run_tick_s;
    logic        adj_tick_s;
    logic        hold_s;
    logic        sec_inc_s;
    logic        min_inc_s;
    logic        sec_max_s;
    logic        min_max_s;

    assign tick1_s  = (cnt_r == TICK1_TERM);
    assign tick_a_s = (adj_cnt_r == TICKA_TERM);

    // Both prescalers free-run in every state so resume latency is 1..CLK_HZ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= 27'd0;
            adj_cnt_r <= 27'd0;
        end else begin
            cnt_r     <= tick1_s  ? 27'd0 : cnt_r + 27'd1;
            adj_cnt_r <= tick_a_s ? 27'd0 : adj_cnt_r + 27'd1;
        end
    end

    assign run_tick_s = (state_r == ST_RUN) && tick1_s;
    assign adj_tick_s = (state_r == ST_ADJUST) && tick_a_s;
    assign hold_s     = !ROLLOVER && sec_max_s && min_max_s;
    assign sec_inc_s  = !clr_p && ((run_tick_s && !hold_s) || (adj_tick_s && !sel));
    assign min_inc_s  = !clr_p && ((run_tick_s && !hold_s && sec_max_s) || (adj_tick_s && sel));

    // Next-state logic: adj overrides everything, clear beats pause.
    always_comb begin
        next_state_s = state_r;
        if (adj) begin
            next_state_s = ST_ADJUST;
        end else if (clr_p) begin
            next_state_s = ST_PAUSED;
        end else begin
            case (state_r)
                ST_PAUSED: next_state_s = pause_p ? ST_RUN : ST_PAUSED;
                ST_RUN: begin
                    if (pause_p || (run_tick_s && hold_s)) begin
                        next_state_s = ST_PAUSED;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_ADJUST: next_state_s = ST_PAUSED;
                default:   next_state_s = ST_PAUSED;
            endcase
        end
    end

    // State register plus a registered copy of the RUN decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_PAUSED;
            running_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            running_r <= (next_state_s == ST_RUN);
        end
    end

    bcd60 u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_p),
        .inc   (sec_inc_s),
        .tens  (sec_l),
        .units (sec_r),
        .carry (sec_max_s)
    );

    bcd60 u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_p),
        .inc   (min_inc_s),
        .tens  (min_l),
        .units (min_r),
        .carry (min_max_s)
    );

    assign blink_cnt = cnt_r;
    assign running   = running_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter at CLK_HZ=10, ADJ_HZ=2; edge numbers
// count rising edges after the last reset edge (E0).
module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pause_p;
    logic        clr_p;
    logic        adj;
    logic        sel;
    logic [4:0]  min_l;
    logic [4:0]  min_r;
    logic [4:0]  sec_l;
    logic [4:0]  sec_r;
    logic [26:0] blink_cnt;
    logic        running;

    int n_asserts = 0;
    int n_fails   = 0;
    int edge_n    = 0;
    int zeros     = 0;

    stopwatch_counter #(.CLK_HZ(10), .ADJ_HZ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pause_p   (pause_p),
        .clr_p     (clr_p),
        .adj       (adj),
        .sel       (sel),
        .min_l     (min_l),
        .min_r     (min_r),
        .sec_l     (sec_l),
        .sec_r     (sec_r),
        .blink_cnt (blink_cnt),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic go(input int k);
        while (edge_n < k) step();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s at E%0d: observed %0d expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int mm, input int ss);
        chk({tag, ".min_l"}, int'(min_l), mm / 10);
        chk({tag, ".min_r"}, int'(min_r), mm % 10);
        chk({tag, ".sec_l"}, int'(sec_l), ss / 10);
        chk({tag, ".sec_r"}, int'(sec_r), ss % 10);
    endtask

    initial begin
        rst_n = 1'b0; pause_p = 1'b0; clr_p = 1'b0; adj = 1'b0; sel = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        edge_n = 0;
        rst_n  = 1'b1;
        chk_time("reset", 0, 0);
        chk("reset.running", int'(running), 0);
        chk("reset.blink", int'(blink_cnt), 0);

        // Start running, count for 100 edges
        pause_p = 1'b1;
        step();
        pause_p = 1'b0;
        chk("start.running", int'(running), 1);
        chk_time("start", 0, 0);
        zeros = 0;
        while (edge_n < 100) begin
            step();
            if (blink_cnt == 27'd0) zeros++;
        end
        chk_time("run100", 0, 10);
        chk("run100.running", int'(running), 1);
        chk("run100.blink", int'(blink_cnt), 0);
        chk("run100.blink_zeros", zeros, 10);

        // Seconds carry into minutes
        go(590);
        chk_time("pre_carry", 0, 59);
        go(599);
        chk_time("pre_tick", 0, 59);
        chk("pre_tick.blink", int'(blink_cnt), 9);
        go(600);
        chk_time("carry", 1, 0);

        // Adjust seconds, then minutes with wrap and no carry
        adj = 1'b1; sel = 1'b0;
        go(625);
        chk_time("adj_sec", 1, 5);
        chk("adj_sec.running", int'(running), 0);
        sel = 1'b1;
        go(910);
        chk_time("adj_min58", 58, 5);
        go(920);
        chk_time("adj_min_wrap", 0, 5);

        // Set 12:34, run, then clear + pause together
        go(980);
        sel = 1'b0;
        go(1125);
        chk_time("set1234", 12, 34);
        adj = 1'b0;
        go(1126);
        pause_p = 1'b1;
        step();
        pause_p = 1'b0;
        chk_time("run1234", 12, 34);
        chk("run1234.running", int'(running), 1);
        clr_p = 1'b1; pause_p = 1'b1;
        step();
        clr_p = 1'b0; pause_p = 1'b0;
        chk_time("clr_pause", 0, 0);
        chk("clr_pause.running", int'(running), 0);

        // Clear + pause with adj=1 lands in ADJUST (seen by the next tickA)
        pause_p = 1'b1;
        step();
        pause_p = 1'b0;
        go(1130);
        chk_time("rerun", 0, 1);
        go(1133);
        clr_p = 1'b1; pause_p = 1'b1; adj = 1'b1;
        step();
        clr_p = 1'b0; pause_p = 1'b0; adj = 1'b0;
        chk_time("clr_adj", 0, 0);
        chk("clr_adj.running", int'(running), 0);
        step();
        chk_time("clr_adj_tick", 0, 1);
        go(1150);
        chk_time("paused_hold", 0, 1);
        chk("paused_hold.running", int'(running), 0);

        // Set 59:59 and take one RUN tick
        adj = 1'b1; sel = 1'b1;
        go(1445);
        sel = 1'b0;
        go(1735);
        chk_time("set5959", 59, 59);
        adj = 1'b0;
        go(1736);
        pause_p = 1'b1;
        step();
        pause_p = 1'b0;
        go(1739);
        chk_time("run5959", 59, 59);
        chk("run5959.running", int'(running), 1);
        go(1740);
`ifdef STOPWATCH_ROLLOVER_EN
        chk_time("top_tick", 0, 0);
        chk("top_tick.running", int'(running), 1);
        go(1750);
        chk_time("after_top", 0, 1);
        chk("after_top.running", int'(running), 1);
`else
        chk_time("top_tick", 59, 59);
        chk("top_tick.running", int'(running), 0);
        go(1750);
        chk_time("after_top", 59, 59);
        chk("after_top.running", int'(running), 0);
`endif

        // Reach 07:07 in ADJUST, then reset for one cycle
        clr_p = 1'b1; adj = 1'b1; sel = 1'b1;
        step();
        clr_p = 1'b0;
        go(1785);
        sel = 1'b0;
        go(1820);
        chk_time("set0707", 7, 7);
        rst_n = 1'b0; adj = 1'b0;
        step();
        rst_n = 1'b1;
        chk_time("mid_reset", 0, 0);
        chk("mid_reset.running", int'(running), 0);
        chk("mid_reset.blink", int'(blink_cnt), 0);
        step();
        chk("post_reset.blink", int'(blink_cnt), 1);
        go(1841);
        chk_time("post_reset_hold", 0, 0);
        chk("post_reset_hold.blink", int'(blink_cnt), 0);
        chk("post_reset_hold.running", int'(running), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
